pc_sequencer: RTL and testbench

//  Registered program-counter unit for the MIPS core. It supersedes the bare

---
 rtl/pc_sequencer.sv | 92 +++++++++
 tb/tb_pc_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered program counter with sequential, branch, jump, call/return and
// exception next-PC selection, plus a small circular return-address stack.
module pc_sequencer #(
  parameter int                WIDTH     = 32,
  parameter int                STEP      = 1,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'('h80),
  parameter int                RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] br_target;
  logic             push_en;

  assign pc_plus   = pc + STEP_W;
  assign br_target = pc_plus + branch_off * STEP_W;
  assign top_ptr   = wr_ptr - PW'(1);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign push_en   = !exc && !stall && !ret && call;

  // The write pointer wraps, so a push while full lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (push_en) ras_mem[wr_ptr] <= pc_plus;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_VEC;
      epc     <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= 1'b0;
      if (exc) begin
        pc     <= EXC_VEC;
        epc    <= pc;
        wr_ptr <= '0;
        count  <= '0;
      end else if (stall) begin
        pc <= pc;
      end else if (ret) begin
        if (count == '0) begin
          pc      <= pc_plus;
          ras_err <= 1'b1;
        end else begin
          pc     <= ras_mem[top_ptr];
          wr_ptr <= top_ptr;
          count  <= count - CW'(1);
        end
      end else if (call) begin
        pc     <= jump_target;
        wr_ptr <= wr_ptr + PW'(1);
        if (count == FULL_CNT) ras_err <= 1'b1;
        else                   count   <= count + CW'(1);
      end else if (jump) begin
        pc <= jump_target;
      end else if (branch_taken) begin
        pc <= br_target;
      end else begin
        pc <= pc_plus;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected pc/ras_err per cycle go through a
// scoreboard queue; flags, epc and async reset are checked directly.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, call, ret, exc;
  logic [31:0] branch_off, jump_target;
  logic [31:0] pc, pc_plus, epc;
  logic        ras_empty, ras_full, ras_err;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_off(branch_off), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .exc(exc), .pc(pc), .pc_plus(pc_plus),
    .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; exc = 0;
    branch_off = '0; jump_target = '0;
  endtask

  // Push the expectation, advance one edge, then pop and compare.
  task automatic cycle(input string tag, input logic [31:0] exp_pc, input logic exp_err);
    exp_t e;
    sb.push_back('{tag, exp_pc, exp_err});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: scoreboard empty observed=%0h expected=entry", tag, pc);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"}, pc, e.pc);
      check({e.tag, ".err"}, {31'b0, ras_err}, {31'b0, e.err});
    end
    clear_inputs();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1;
    #12 reset = 0;
    #1;
    check("rst.pc", pc, 32'h0);
    check("rst.pc_plus", pc_plus, 32'h1);
    check("rst.epc", epc, 32'h0);
    check("rst.empty", {31'b0, ras_empty}, 32'h1);
    check("rst.full", {31'b0, ras_full}, 32'h0);
    check("rst.err", {31'b0, ras_err}, 32'h0);

    cycle("idle1", 32'd1, 0);
    cycle("idle2", 32'd2, 0);
    cycle("idle3", 32'd3, 0);
    cycle("idle4", 32'd4, 0);
    cycle("idle5", 32'd5, 0);

    branch_taken = 1; branch_off = -32'sd2;
    cycle("branch", 32'd4, 0);
    stall = 1; branch_taken = 1; branch_off = 32'd7;
    cycle("stall1", 32'd4, 0);
    stall = 1; jump = 1; jump_target = 32'd99;
    cycle("stall2", 32'd4, 0);

    jump = 1; jump_target = 32'd10;
    cycle("jump10", 32'd10, 0);
    call = 1; jump_target = 32'd40;
    cycle("call40", 32'd40, 0);
    check("call40.empty", {31'b0, ras_empty}, 32'h0);
    ret = 1;
    cycle("ret11", 32'd11, 0);
    check("ret11.empty", {31'b0, ras_empty}, 32'h1);

    call = 1; jump_target = 32'd100; cycle("call1", 32'd100, 0);
    call = 1; jump_target = 32'd200; cycle("call2", 32'd200, 0);
    call = 1; jump_target = 32'd300; cycle("call3", 32'd300, 0);
    call = 1; jump_target = 32'd400; cycle("call4", 32'd400, 0);
    check("call4.full", {31'b0, ras_full}, 32'h1);
    call = 1; jump_target = 32'd500; cycle("call5", 32'd500, 1);
    check("call5.full", {31'b0, ras_full}, 32'h1);
    cycle("idle501", 32'd501, 0);
    ret = 1; cycle("ret1", 32'd401, 0);
    ret = 1; cycle("ret2", 32'd301, 0);
    ret = 1; cycle("ret3", 32'd201, 0);
    ret = 1; cycle("ret4", 32'd101, 0);
    check("ret4.empty", {31'b0, ras_empty}, 32'h1);
    ret = 1; cycle("ret5", 32'd102, 1);

    call = 1; jump_target = 32'd600; cycle("call600", 32'd600, 0);
    call = 1; ret = 1; jump_target = 32'd700; cycle("callret", 32'd103, 0);
    check("callret.empty", {31'b0, ras_empty}, 32'h1);

    call = 1; jump_target = 32'd20; cycle("call20", 32'd20, 0);
    check("call20.empty", {31'b0, ras_empty}, 32'h0);
    stall = 1; exc = 1; cycle("exc", 32'h80, 0);
    check("exc.epc", epc, 32'd20);
    check("exc.empty", {31'b0, ras_empty}, 32'h1);

    jump = 1; jump_target = 32'hFFFF_FFFF; cycle("jmax", 32'hFFFF_FFFF, 0);
    check("jmax.pc_plus", pc_plus, 32'h0);
    cycle("wrap", 32'h0, 0);
    cycle("post", 32'h1, 0);

    #3 reset = 1; jump = 1; jump_target = 32'd55;
    #1;
    check("async.pc", pc, 32'h0);
    check("async.epc", epc, 32'h0);
    check("async.empty", {31'b0, ras_empty}, 32'h1);
    @(posedge clk); #1;
    check("hold.pc", pc, 32'h0);
    clear_inputs();
    reset = 0;
    cycle("after", 32'h1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
